// File: rtl/riscv_multiplier_iter.sv
// Iterative RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU), BITS_PER_CYCLE multiplier bits per cycle.
// Optional macro RISCV_MUL_FUSE_EN: cache the last high-half product so a following MUL can skip RUN.
module riscv_multiplier_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            opcode_valid_i,
    input  logic [31:0]     opcode_opcode_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            hold_i,
    output logic [XLEN-1:0] writeback_value_o,
    output logic            writeback_valid_o,
    output logic            busy_o
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic signed [PW-1:0] acc_q, acc_nxt, a_sh_q;
    logic [XLEN-1:0]      b_sh_q;
    logic                 hi_sel_q, b_neg_q;
    logic [XLEN-1:0]      wb_value_q;

    logic [6:0] op_major, funct7;
    logic [2:0] funct3;
    logic       dec_mul, op_lo, a_signed, b_signed;
    logic       accept, fuse_hit, step, last_step;
    logic       unused_bits;

    function automatic logic signed [PW-1:0] partial_prod(input logic signed [PW-1:0] a,
                                                          input logic [BITS_PER_CYCLE-1:0] d);
        logic signed [PW-1:0] s;
        s = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++)
            if (d[j]) s = s + (a <<< j);
        return s;
    endfunction

    function automatic logic signed [PW-1:0] ext_operand(input logic [XLEN-1:0] v, input logic sgn);
        return signed'({{XLEN{sgn & v[XLEN-1]}}, v});
    endfunction

    function automatic logic [XLEN-1:0] select_half(input logic [PW-1:0] p, input logic hi);
        return hi ? p[PW-1:XLEN] : p[XLEN-1:0];
    endfunction

    assign op_major  = opcode_opcode_i[6:0];
    assign funct3    = opcode_opcode_i[14:12];
    assign funct7    = opcode_opcode_i[31:25];
    assign dec_mul   = opcode_valid_i && (op_major == 7'b0110011) && (funct7 == 7'b0000001) && !funct3[2];
    assign op_lo     = (funct3 == 3'b000);
    assign a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010);
    assign b_signed  = (funct3 == 3'b001);
    assign accept    = (state_q == IDLE) && dec_mul && !hold_i;
    assign step      = (state_q == RUN) && !hold_i;
    assign last_step = step && (cnt_q == CW'(1));

    // b is consumed as unsigned; a negative signed b is fixed by subtracting a<<XLEN on the last step
    always_comb begin
        acc_nxt = acc_q + partial_prod(a_sh_q, b_sh_q[BITS_PER_CYCLE-1:0]);
        if ((cnt_q == CW'(1)) && b_neg_q)
            acc_nxt = acc_nxt - (a_sh_q <<< BITS_PER_CYCLE);
    end

`ifdef RISCV_MUL_FUSE_EN
    logic            cache_vld_q, same_ops;
    logic [XLEN-1:0] cache_a_q, cache_b_q;
    logic [PW-1:0]   cache_prod_q;

    assign same_ops    = (opcode_ra_operand_i == cache_a_q) && (opcode_rb_operand_i == cache_b_q);
    assign fuse_hit    = cache_vld_q && op_lo && same_ops;
    assign unused_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7], cache_prod_q[PW-1:XLEN]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cache_vld_q <= 1'b0;
        else if (accept && !same_ops)
            cache_vld_q <= 1'b0;
        else if (last_step)
            cache_vld_q <= hi_sel_q;
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            cache_a_q <= opcode_ra_operand_i;
            cache_b_q <= opcode_rb_operand_i;
        end
        if (last_step)
            cache_prod_q <= acc_nxt;
    end
`else
    assign fuse_hit    = 1'b0;
    assign unused_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7]};
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fuse_hit ? DONE : RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (!hold_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_value_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                cnt_q <= fuse_hit ? '0 : CW'(N);
            else if (step)
                cnt_q <= cnt_q - CW'(1);
            if (last_step)
                wb_value_q <= select_half(acc_nxt, hi_sel_q);
`ifdef RISCV_MUL_FUSE_EN
            else if (accept && fuse_hit)
                wb_value_q <= cache_prod_q[XLEN-1:0];
`endif
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept before use
    always_ff @(posedge clk_i) begin
        if (accept) begin
            a_sh_q   <= ext_operand(opcode_ra_operand_i, a_signed);
            b_sh_q   <= opcode_rb_operand_i;
            acc_q    <= '0;
            hi_sel_q <= !op_lo;
            b_neg_q  <= b_signed & opcode_rb_operand_i[XLEN-1];
        end else if (step) begin
            acc_q  <= acc_nxt;
            a_sh_q <= a_sh_q <<< BITS_PER_CYCLE;
            b_sh_q <= b_sh_q >> BITS_PER_CYCLE;
        end
    end

    always_comb begin
        busy_o            = (state_q != IDLE);
        writeback_valid_o = (state_q == DONE);
        writeback_value_o = wb_value_q;
    end

endmodule

// File: tb/tb_riscv_multiplier_iter.sv
// Directed testbench for riscv_multiplier_iter with default parameters (XLEN=32, BITS_PER_CYCLE=4).
module tb_riscv_multiplier_iter;

    localparam logic [31:0] OP_MUL    = 32'h02000033;
    localparam logic [31:0] OP_MULH   = 32'h02001033;
    localparam logic [31:0] OP_MULHSU = 32'h02002033;
    localparam logic [31:0] OP_MULHU  = 32'h02003033;
    localparam logic [31:0] OP_ADD    = 32'h00000033;
    localparam logic [31:0] OP_DIV    = 32'h02004033;
    localparam int          LAT       = 9;
`ifdef RISCV_MUL_FUSE_EN
    localparam int          FUSE_LAT  = 1;
`else
    localparam int          FUSE_LAT  = 9;
`endif

    logic        clk_i, rst_n_i, opcode_valid_i, hold_i;
    logic [31:0] opcode_opcode_i, opcode_ra_operand_i, opcode_rb_operand_i;
    logic [31:0] writeback_value_o;
    logic        writeback_valid_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    riscv_multiplier_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .opcode_valid_i      (opcode_valid_i),
        .opcode_opcode_i     (opcode_opcode_i),
        .opcode_ra_operand_i (opcode_ra_operand_i),
        .opcode_rb_operand_i (opcode_rb_operand_i),
        .hold_i              (hold_i),
        .writeback_value_o   (writeback_value_o),
        .writeback_valid_o   (writeback_valid_o),
        .busy_o              (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one instruction for a single cycle; returns after the accept edge (cycle 1)
    task automatic present(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        opcode_valid_i      = 1'b1;
        opcode_opcode_i     = instr;
        opcode_ra_operand_i = a;
        opcode_rb_operand_i = b;
        tick();
        opcode_valid_i = 1'b0;
    endtask

    // Poll from cycle k0 until writeback_valid_o; lat=-1 on timeout
    task automatic wait_valid(input int k0, output int lat, output logic [31:0] val, output logic busy_ok);
        lat     = -1;
        val     = '0;
        busy_ok = 1'b1;
        for (int k = k0; k <= k0 + 40; k++) begin
            if (!busy_o) busy_ok = 1'b0;
            if (writeback_valid_o) begin
                lat = k;
                val = writeback_value_o;
                break;
            end
            tick();
        end
    endtask

    task automatic watch_quiet(input int cycles, output logic seen_busy, output logic seen_valid);
        seen_busy  = 1'b0;
        seen_valid = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            if (busy_o) seen_busy = 1'b1;
            if (writeback_valid_o) seen_valid = 1'b1;
            tick();
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] instr, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int          lat;
        logic [31:0] val;
        logic        busy_ok;
        present(instr, a, b);
        wait_valid(1, lat, val, busy_ok);
        check({name, "_value"}, val, exp);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy"}, busy_ok, 1'b1);
        tick();
        check({name, "_idle"}, {busy_o, writeback_valid_o}, 2'b00);
    endtask

    initial begin
        int          lat;
        logic [31:0] val;
        logic        busy_ok, seen_busy, seen_valid;

        vecs[0]  = '{OP_MUL,    32'd3,        32'd7,        32'h00000015};
        vecs[1]  = '{OP_MULH,   32'hFFFFFFFE, 32'd7,        32'hFFFFFFFF};
        vecs[2]  = '{OP_MULHU,  32'hFFFF0000, 32'h0000FFFF, 32'h0000FFFE};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vecs[4]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        vecs[5]  = '{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[6]  = '{OP_MUL,    32'd0,        32'd0,        32'h00000000};
        vecs[7]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[8]  = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[9]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{OP_MULH,   32'h7FFFFFFF, 32'h80000000, 32'hC0000000};
        vecs[11] = '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780};

        rst_n_i             = 1'b0;
        opcode_valid_i      = 1'b0;
        opcode_opcode_i     = '0;
        opcode_ra_operand_i = '0;
        opcode_rb_operand_i = '0;
        hold_i              = 1'b0;
        tick();
        tick();
        check("reset_outputs", {busy_o, writeback_valid_o, writeback_value_o}, 34'd0);
        rst_n_i = 1'b1;
        tick();

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].exp, LAT);

        // Hold for 3 cycles mid-RUN, then 2 cycles in DONE
        present(OP_MUL, 32'd5, 32'd6);
        tick();
        tick();
        hold_i = 1'b1;
        tick();
        tick();
        tick();
        hold_i = 1'b0;
        wait_valid(6, lat, val, busy_ok);
        check("hold_run_latency", lat, 12);
        check("hold_run_value", val, 32'h0000001E);
        hold_i = 1'b1;
        tick();
        check("hold_done_1", {writeback_valid_o, writeback_value_o}, {1'b1, 32'h0000001E});
        tick();
        check("hold_done_2", {writeback_valid_o, writeback_value_o}, {1'b1, 32'h0000001E});
        hold_i = 1'b0;
        tick();
        check("hold_done_release", {busy_o, writeback_valid_o}, 2'b00);

        // Asynchronous reset in cycle 4 of an op
        present(OP_MUL, 32'd3, 32'd7);
        tick();
        tick();
        tick();
        rst_n_i = 1'b0;
        #1;
        check("midop_reset_outputs", {busy_o, writeback_valid_o, writeback_value_o}, 34'd0);
        #2;
        rst_n_i = 1'b1;
        tick();
        watch_quiet(15, seen_busy, seen_valid);
        check("midop_reset_no_strobe", {seen_busy, seen_valid}, 2'b00);
        run_op("after_reset", OP_MUL, 32'd2, 32'd2, 32'h00000004, LAT);

        // Non-multiply words are ignored
        present(OP_ADD, 32'd3, 32'd7);
        watch_quiet(12, seen_busy, seen_valid);
        check("add_ignored", {seen_busy, seen_valid}, 2'b00);
        present(OP_DIV, 32'd3, 32'd7);
        watch_quiet(12, seen_busy, seen_valid);
        check("div_ignored", {seen_busy, seen_valid}, 2'b00);

        // A valid mul presented with hold_i=1 in IDLE is not accepted
        hold_i = 1'b1;
        present(OP_MUL, 32'd3, 32'd7);
        hold_i = 1'b0;
        watch_quiet(12, seen_busy, seen_valid);
        check("hold_idle_no_accept", {seen_busy, seen_valid}, 2'b00);

        // Second MUL while busy is dropped
        present(OP_MUL, 32'd3, 32'd7);
        present(OP_MUL, 32'd4, 32'd5);
        wait_valid(2, lat, val, busy_ok);
        check("busy_drop_value", val, 32'h00000015);
        check("busy_drop_latency", lat, LAT);
        tick();
        watch_quiet(12, seen_busy, seen_valid);
        check("busy_drop_no_second", {seen_busy, seen_valid}, 2'b00);

        // High-then-low sequence on identical operands
        run_op("fuse_hi", OP_MULHU, 32'hFFFF0000, 32'h0000FFFF, 32'h0000FFFE, LAT);
        run_op("fuse_lo", OP_MUL, 32'hFFFF0000, 32'h0000FFFF, 32'h00010000, FUSE_LAT);
        run_op("fuse_other", OP_MUL, 32'h00000003, 32'h0000FFFF, 32'h0002FFFD, LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
